load_store_unit: RTL and testbench

Memory-stage access initiator that drives the word-organised data memory port: `mem_read`, `mem_write`, a 6-bit byte address, and 32-bit write and read data. The memory's read is combinational and its write lands on the clock edge. The unit accepts one load or store per request from the pipeline and supports RISC-V byte, halfword and word widths. Sub-word stores use a read-modify-write sequence; loads are sign- or zero-extended. Misaligned and illegal accesses return an error without touching memory.

---
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 tb/tb_load_store_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator: byte/half/word accesses, RMW for sub-word stores.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [5:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_MRD  = 3'd3,
    S_MWR  = 3'd4,
    S_RESP = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   merge_q, merge_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            req_illegal, req_misaligned;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [DW-1:0]   load_ext;
  logic [DW-1:0]   lane_mask, lane_data, merged_word;

  // Classify the incoming request so the first state can be chosen at the accept edge
  always_comb begin
    req_illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
      3'b100, 3'b101:         req_illegal = req_we;
      default:                req_illegal = 1'b1;
    endcase
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  end

  // Lane extraction and sign/zero extension of the read word
  always_comb begin
    byte_lane = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
    half_lane = 16'(mem_rdata >> {addr_q[1], 4'b0000});
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = {{16{~funct3_q[2] & half_lane[15]}}, half_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  // Replace the target lane of the captured word with the store data
  always_comb begin
    if (funct3_q[1:0] == 2'b00) begin
      lane_mask = DW'(32'h0000_00FF) << {addr_q[1:0], 3'b000};
      lane_data = DW'({24'd0, wdata_q[7:0]}) << {addr_q[1:0], 3'b000};
    end else begin
      lane_mask = DW'(32'h0000_FFFF) << {addr_q[1], 4'b0000};
      lane_data = DW'({16'd0, wdata_q[15:0]}) << {addr_q[1], 4'b0000};
    end
    merged_word = (merge_q & ~lane_mask) | (lane_data & lane_mask);
  end

  // Next-state and register-update logic
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          merge_d  = '0;
          rdata_d  = '0;
          err_d    = req_illegal | req_misaligned;
          if (req_illegal || req_misaligned) state_d = S_RESP;
          else if (!req_we)                  state_d = S_RD;
          else if (req_funct3 == 3'b010)     state_d = S_WR;
          else                               state_d = S_MRD;
        end
      end
      S_RD: begin
        rdata_d = load_ext;
        state_d = S_RESP;
      end
      S_WR:  state_d = S_RESP;
      S_MRD: begin
        merge_d = mem_rdata;
        state_d = S_MWR;
      end
      S_MWR:  state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Outputs decoded from the state register so reset drops strobes immediately
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_RD, S_MRD: begin
        mem_read = 1'b1;
        mem_addr = {addr_q[5:2], 2'b00};
      end
      S_WR: begin
        mem_write = 1'b1;
        mem_addr  = {addr_q[5:2], 2'b00};
        mem_wdata = wdata_q;
      end
      S_MWR: begin
        mem_write = 1'b1;
        mem_addr  = {addr_q[5:2], 2'b00};
        mem_wdata = merged_word;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [16];
  int asserts = 0;
  int fails = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read, write on the rising edge
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;

  // Present a request at a falling edge; it is accepted at the next rising edge
  task automatic drive(input logic we, input logic [2:0] f3, input logic [5:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[0] = 32'd17; mem[1] = 32'd9; mem[2] = 32'd25;
    #12;
    asserts++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
    asserts++; if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0000) begin fails++; $display("FAIL reset_strobes: got %b exp 0000", {resp_valid, resp_err, mem_read, mem_write}); end
    asserts++; if ({resp_rdata, mem_addr, mem_wdata} !== 70'd0) begin fails++; $display("FAIL reset_data: got %h exp 0", {resp_rdata, mem_addr, mem_wdata}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_word_load();
    drive(1'b0, 3'b010, 6'd4, 32'd0);
    @(negedge clk); req_valid = 1'b0;
    asserts++; if ({mem_read, mem_write, mem_addr} !== {2'b10, 6'd4}) begin fails++; $display("FAIL lw_strobe: got rd=%b wr=%b addr=%0d exp rd=1 wr=0 addr=4", mem_read, mem_write, mem_addr); end
    asserts++; if (req_ready !== 1'b0) begin fails++; $display("FAIL lw_busy: got %b exp 0", req_ready); end
    @(negedge clk);
    asserts++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'd9}) begin fails++; $display("FAIL lw_resp: got v=%b e=%b d=%h exp v=1 e=0 d=9", resp_valid, resp_err, resp_rdata); end
    @(negedge clk);
    asserts++; if ({resp_valid, req_ready, resp_rdata} !== {2'b01, 32'd0}) begin fails++; $display("FAIL lw_done: got v=%b rdy=%b d=%h exp v=0 rdy=1 d=0", resp_valid, req_ready, resp_rdata); end
  endtask

  task automatic test_byte_store();
    drive(1'b1, 3'b000, 6'd1, 32'h0000_00AB);
    @(negedge clk); req_valid = 1'b0;
    asserts++; if ({mem_read, mem_write, mem_addr} !== {2'b10, 6'd0}) begin fails++; $display("FAIL sb_mrd: got rd=%b wr=%b addr=%0d exp rd=1 wr=0 addr=0", mem_read, mem_write, mem_addr); end
    @(negedge clk);
    asserts++; if ({mem_read, mem_write, mem_wdata} !== {2'b01, 32'h0000_AB11}) begin fails++; $display("FAIL sb_mwr: got rd=%b wr=%b wd=%h exp rd=0 wr=1 wd=0000ab11", mem_read, mem_write, mem_wdata); end
    asserts++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL sb_early_resp: got %b exp 0", resp_valid); end
    @(negedge clk);
    asserts++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'd0}) begin fails++; $display("FAIL sb_resp: got v=%b e=%b d=%h exp v=1 e=0 d=0", resp_valid, resp_err, resp_rdata); end
    asserts++; if (mem[0] !== 32'h0000_AB11) begin fails++; $display("FAIL sb_memword: got %h exp 0000ab11", mem[0]); end
  endtask

  task automatic test_load_extension();
    logic [2:0]  f3  [5];
    logic [5:0]  ad  [5];
    logic        we  [5];
    logic [31:0] wd  [5];
    logic [31:0] exp [5];
    f3[0] = 3'b000; ad[0] = 6'd1; we[0] = 1'b0; wd[0] = 32'd0;      exp[0] = 32'hFFFF_FFAB;
    f3[1] = 3'b100; ad[1] = 6'd1; we[1] = 1'b0; wd[1] = 32'd0;      exp[1] = 32'h0000_00AB;
    f3[2] = 3'b001; ad[2] = 6'd2; we[2] = 1'b1; wd[2] = 32'h8001;   exp[2] = 32'h0000_0000;
    f3[3] = 3'b001; ad[3] = 6'd2; we[3] = 1'b0; wd[3] = 32'd0;      exp[3] = 32'hFFFF_8001;
    f3[4] = 3'b101; ad[4] = 6'd2; we[4] = 1'b0; wd[4] = 32'd0;      exp[4] = 32'h0000_8001;
    for (int i = 0; i < 5; i++) begin
      drive(we[i], f3[i], ad[i], wd[i]);
      @(negedge clk); req_valid = 1'b0;
      if (we[i]) @(negedge clk);
      @(negedge clk);
      asserts++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, exp[i]}) begin fails++; $display("FAIL ext_%0d: got v=%b e=%b d=%h exp v=1 e=0 d=%h", i, resp_valid, resp_err, resp_rdata, exp[i]); end
    end
    asserts++; if (mem[0] !== 32'h8001_AB11) begin fails++; $display("FAIL sh_memword: got %h exp 8001ab11", mem[0]); end
  endtask

  task automatic test_errors();
    logic        we [4];
    logic [2:0]  f3 [4];
    logic [5:0]  ad [4];
    we[0] = 1'b0; f3[0] = 3'b001; ad[0] = 6'd3;
    we[1] = 1'b1; f3[1] = 3'b010; ad[1] = 6'd6;
    we[2] = 1'b1; f3[2] = 3'b100; ad[2] = 6'd0;
    we[3] = 1'b0; f3[3] = 3'b011; ad[3] = 6'd0;
    for (int i = 0; i < 4; i++) begin
      drive(we[i], f3[i], ad[i], 32'hFFFF_FFFF);
      @(negedge clk); req_valid = 1'b0;
      asserts++; if ({resp_valid, resp_err, resp_rdata, mem_read, mem_write} !== {2'b11, 32'd0, 2'b00}) begin fails++; $display("FAIL err_%0d: got v=%b e=%b d=%h rd=%b wr=%b exp v=1 e=1 d=0 rd=0 wr=0", i, resp_valid, resp_err, resp_rdata, mem_read, mem_write); end
      @(negedge clk);
      asserts++; if ({resp_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL err_done_%0d: got v=%b rdy=%b exp v=0 rdy=1", i, resp_valid, req_ready); end
    end
    asserts++; if ({mem[0], mem[1]} !== {32'h8001_AB11, 32'd9}) begin fails++; $display("FAIL err_mem: got %h %h exp 8001ab11 00000009", mem[0], mem[1]); end
  endtask

  task automatic test_reset_in_mwr();
    drive(1'b1, 3'b000, 6'd9, 32'h0000_00EE);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    asserts++; if ({mem_write, mem_addr} !== {1'b1, 6'd8}) begin fails++; $display("FAIL rst_pre_mwr: got wr=%b addr=%0d exp wr=1 addr=8", mem_write, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    asserts++; if ({mem_write, mem_read, resp_valid, req_ready} !== 4'b0001) begin fails++; $display("FAIL rst_mid: got wr=%b rd=%b v=%b rdy=%b exp wr=0 rd=0 v=0 rdy=1", mem_write, mem_read, resp_valid, req_ready); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      asserts++; if ({resp_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL rst_after_%0d: got v=%b rdy=%b exp v=0 rdy=1", i, resp_valid, req_ready); end
    end
    asserts++; if (mem[2] !== 32'd25) begin fails++; $display("FAIL rst_word2: got %h exp 00000019", mem[2]); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'b010, 6'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    asserts++; if ({req_ready, mem_write, mem_wdata} !== {2'b01, 32'hDEAD_BEEF}) begin fails++; $display("FAIL b2b_wr: got rdy=%b wr=%b wd=%h exp rdy=0 wr=1 wd=deadbeef", req_ready, mem_write, mem_wdata); end
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 6'd0; req_wdata = 32'd0;
    @(negedge clk);
    asserts++; if ({resp_valid, req_ready} !== 2'b10) begin fails++; $display("FAIL b2b_resp1: got v=%b rdy=%b exp v=1 rdy=0", resp_valid, req_ready); end
    @(negedge clk);
    asserts++; if ({resp_valid, req_ready, mem_read} !== 3'b010) begin fails++; $display("FAIL b2b_idle: got v=%b rdy=%b rd=%b exp v=0 rdy=1 rd=0", resp_valid, req_ready, mem_read); end
    @(negedge clk); req_valid = 1'b0;
    asserts++; if ({req_ready, mem_read, mem_addr} !== {2'b01, 6'd0}) begin fails++; $display("FAIL b2b_rd: got rdy=%b rd=%b addr=%0d exp rdy=0 rd=1 addr=0", req_ready, mem_read, mem_addr); end
    @(negedge clk);
    asserts++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin fails++; $display("FAIL b2b_resp2: got v=%b e=%b d=%h exp v=1 e=0 d=deadbeef", resp_valid, resp_err, resp_rdata); end
    @(negedge clk);
    asserts++; if ({resp_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL b2b_done: got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_load_extension();
    test_errors();
    test_reset_in_mwr();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
